// File: rtl/branch_predictor_if.sv
// Fetch-lookup and resolve-update signal bundle for the branch predictor.
interface branch_predictor_if;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [1:0]  upd_br_type;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic        mispredict;
   logic [31:0] br_cnt;
   logic [31:0] miss_cnt;

   modport master (
      output if_pc, upd_valid, upd_pc, upd_br_type, upd_taken, upd_target,
             upd_pred_taken, upd_pred_target,
      input  pred_taken, pred_target, mispredict, br_cnt, miss_cnt
   );

   modport slave (
      input  if_pc, upd_valid, upd_pc, upd_br_type, upd_taken, upd_target,
             upd_pred_taken, upd_pred_target,
      output pred_taken, pred_target, mispredict, br_cnt, miss_cnt
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; zero-latency lookup,
// single-write-per-cycle resolve update, and branch/miss statistics.
module branch_predictor #(
   parameter int unsigned IDX_BITS = 4
) (
   input  logic               clk,
   input  logic               rst,
   branch_predictor_if.slave  bp
);
   localparam int unsigned ENTRIES = 1 << IDX_BITS;
   localparam int unsigned TAG_W   = 32 - IDX_BITS - 2;

   logic             r_valid  [ENTRIES];
   logic [TAG_W-1:0] r_tag    [ENTRIES];
   logic [31:0]      r_target [ENTRIES];
   logic [1:0]       r_ctr    [ENTRIES];
   logic [31:0]      r_br_cnt;
   logic [31:0]      r_miss_cnt;

   logic [IDX_BITS-1:0] w_lk_idx;
   logic [TAG_W-1:0]    w_lk_tag;
   logic                w_lk_hit;
   logic [IDX_BITS-1:0] w_up_idx;
   logic [TAG_W-1:0]    w_up_tag;
   logic                w_up_hit;
   logic                w_cond;
   logic                w_mispredict;

   // Lookup reads the registered table, so same-index updates show next cycle.
   assign w_lk_idx = bp.if_pc[IDX_BITS+1:2];
   assign w_lk_tag = bp.if_pc[31:IDX_BITS+2];
   assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

   assign bp.pred_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
   assign bp.pred_target = bp.pred_taken ? r_target[w_lk_idx] : (bp.if_pc + 32'd4);

   assign w_up_idx = bp.upd_pc[IDX_BITS+1:2];
   assign w_up_tag = bp.upd_pc[31:IDX_BITS+2];
   assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
   assign w_cond   = bp.upd_valid && ((bp.upd_br_type == 2'b01) || (bp.upd_br_type == 2'b10));

   assign w_mispredict = w_cond && ((bp.upd_pred_taken != bp.upd_taken) ||
                         (bp.upd_taken && (bp.upd_pred_target != bp.upd_target)));
   assign bp.mispredict = w_mispredict;
   assign bp.br_cnt     = r_br_cnt;
   assign bp.miss_cnt   = r_miss_cnt;

   // Table update: train on hit, allocate only on taken miss.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            r_valid[i] <= 1'b0;
            r_ctr[i]   <= 2'b01;
         end
         r_br_cnt   <= 32'd0;
         r_miss_cnt <= 32'd0;
      end else begin
         if (w_cond) begin
            if (w_up_hit) begin
               if (bp.upd_taken) begin
                  if (r_ctr[w_up_idx] != 2'b11) r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
                  r_target[w_up_idx] <= bp.upd_target;
               end else if (r_ctr[w_up_idx] != 2'b00) begin
                  r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
               end
            end else if (bp.upd_taken) begin
               r_valid[w_up_idx]  <= 1'b1;
               r_tag[w_up_idx]    <= w_up_tag;
               r_target[w_up_idx] <= bp.upd_target;
               r_ctr[w_up_idx]    <= 2'b10;
            end
            if (r_br_cnt != 32'hFFFF_FFFF) r_br_cnt <= r_br_cnt + 32'd1;
         end
         if (w_mispredict && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: stimulus pushes expected
// outputs, a negedge monitor pops and compares them.
module tb_branch_predictor;
   logic clk = 1'b0;
   logic rst;
   branch_predictor_if bif ();

   branch_predictor #(.IDX_BITS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bp  (bif)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        pt;
      logic [31:0] ptgt;
      logic        mp;
      int unsigned bc;
      int unsigned mc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s got %h expected %h", nm, fld, act, req);
      end
   endtask

   // Monitor: lookup/mispredict/counters are live every cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk(e.name, "pred_taken", 32'(bif.pred_taken), 32'(e.pt));
         chk(e.name, "pred_target", bif.pred_target, e.ptgt);
         chk(e.name, "mispredict", 32'(bif.mispredict), 32'(e.mp));
         chk(e.name, "br_cnt", bif.br_cnt, e.bc);
         chk(e.name, "miss_cnt", bif.miss_cnt, e.mc);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic v, input logic [31:0] pc, input logic [1:0] ty, input logic tk,
                      input logic [31:0] tg, input logic ptk, input logic [31:0] ptg);
      bif.upd_valid       = v;
      bif.upd_pc          = pc;
      bif.upd_br_type     = ty;
      bif.upd_taken       = tk;
      bif.upd_target      = tg;
      bif.upd_pred_taken  = ptk;
      bif.upd_pred_target = ptg;
   endtask

   task automatic noupd();
      upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic expect_out(input string n, input logic pt, input logic [31:0] tg, input logic mp,
                             input int unsigned bc, input int unsigned mc);
      exp_t e;
      e.name = n; e.pt = pt; e.ptgt = tg; e.mp = mp; e.bc = bc; e.mc = mc;
      exp_q.push_back(e);
   endtask

   initial begin
      rst = 1'b1;
      bif.if_pc = 32'h0;
      noupd();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Cold miss after reset
      bif.if_pc = 32'h40; noupd();
      expect_out("cold_miss", 1'b0, 32'h44, 1'b0, 0, 0);
      // Allocate; same-index lookup still sees pre-update contents
      cyc(); upd(1'b1, 32'h40, 2'b01, 1'b1, 32'h80, 1'b0, 32'h44);
      expect_out("alloc", 1'b0, 32'h44, 1'b1, 0, 0);
      cyc(); noupd();
      expect_out("alloc_hit", 1'b1, 32'h80, 1'b0, 1, 1);
      // Saturation: ctr 10 -> 11 -> 11 -> 10 -> 01 -> 00 -> 00
      cyc(); upd(1'b1, 32'h40, 2'b10, 1'b1, 32'h80, 1'b1, 32'h80);
      expect_out("sat_t1", 1'b1, 32'h80, 1'b0, 1, 1);
      cyc(); upd(1'b1, 32'h40, 2'b10, 1'b1, 32'h80, 1'b1, 32'h80);
      expect_out("sat_t2", 1'b1, 32'h80, 1'b0, 2, 1);
      cyc(); upd(1'b1, 32'h40, 2'b01, 1'b0, 32'h80, 1'b1, 32'h80);
      expect_out("sat_nt1", 1'b1, 32'h80, 1'b1, 3, 1);
      cyc(); upd(1'b1, 32'h40, 2'b01, 1'b0, 32'h80, 1'b1, 32'h80);
      expect_out("sat_nt2", 1'b1, 32'h80, 1'b1, 4, 2);
      cyc(); upd(1'b1, 32'h40, 2'b01, 1'b0, 32'h80, 1'b0, 32'h44);
      expect_out("sat_nt3", 1'b0, 32'h44, 1'b0, 5, 3);
      cyc(); upd(1'b1, 32'h40, 2'b01, 1'b0, 32'h80, 1'b0, 32'h44);
      expect_out("sat_floor", 1'b0, 32'h44, 1'b0, 6, 3);
      // Retrain 00 -> 01 -> 10, then target mismatch on a taken hit
      cyc(); upd(1'b1, 32'h40, 2'b01, 1'b1, 32'h80, 1'b0, 32'h44);
      expect_out("retrain1", 1'b0, 32'h44, 1'b1, 7, 3);
      cyc(); upd(1'b1, 32'h40, 2'b01, 1'b1, 32'h80, 1'b0, 32'h44);
      expect_out("retrain2", 1'b0, 32'h44, 1'b1, 8, 4);
      cyc(); upd(1'b1, 32'h40, 2'b01, 1'b1, 32'h90, 1'b1, 32'h80);
      expect_out("tgt_mismatch", 1'b1, 32'h80, 1'b1, 9, 5);
      cyc(); noupd();
      expect_out("tgt_new", 1'b1, 32'h90, 1'b0, 10, 6);
      // Non-conditional updates change nothing and never mispredict
      cyc(); upd(1'b1, 32'h40, 2'b00, 1'b0, 32'h0, 1'b1, 32'h90);
      expect_out("type00", 1'b1, 32'h90, 1'b0, 10, 6);
      cyc(); upd(1'b1, 32'h40, 2'b11, 1'b0, 32'h0, 1'b1, 32'h90);
      expect_out("type11", 1'b1, 32'h90, 1'b0, 10, 6);
      cyc(); upd(1'b0, 32'h40, 2'b01, 1'b0, 32'h0, 1'b1, 32'h90);
      expect_out("invalid", 1'b1, 32'h90, 1'b0, 10, 6);
      // Alias 0x440 onto index of 0x40
      cyc(); bif.if_pc = 32'h440; upd(1'b1, 32'h440, 2'b01, 1'b1, 32'h200, 1'b0, 32'h444);
      expect_out("alias_alloc", 1'b0, 32'h444, 1'b1, 10, 6);
      cyc(); bif.if_pc = 32'h40; noupd();
      expect_out("alias_evict", 1'b0, 32'h44, 1'b0, 11, 7);
      cyc(); bif.if_pc = 32'h440;
      expect_out("alias_hit", 1'b1, 32'h200, 1'b0, 11, 7);
      cyc(); bif.if_pc = 32'h442;
      expect_out("low_bits", 1'b1, 32'h200, 1'b0, 11, 7);
      cyc(); bif.if_pc = 32'hFFFF_FFFC;
      expect_out("pc_wrap", 1'b0, 32'h0, 1'b0, 11, 7);
      // Reset overrides a same-cycle taken update
      cyc(); rst = 1'b1; bif.if_pc = 32'h440; upd(1'b1, 32'h440, 2'b01, 1'b1, 32'h300, 1'b1, 32'h200);
      expect_out("rst_upd", 1'b1, 32'h200, 1'b1, 11, 7);
      cyc(); rst = 1'b0; noupd();
      expect_out("post_rst", 1'b0, 32'h444, 1'b0, 0, 0);
      cyc(); bif.if_pc = 32'h40;
      expect_out("post_rst2", 1'b0, 32'h44, 1'b0, 0, 0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
